// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between requesters, the round-robin scheduler and the uart_tx datapath.
// master: scheduler side; slave: client/transmitter side.
interface uart_tx_sched_if #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATAWIDTH = 5
);
   localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*DATAWIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]           ack;
   logic [NUM_REQ-1:0]           done;
   logic                         tx_start;
   logic [DATAWIDTH-1:0]         tx_data;
   logic                         tx_busy;
   logic [GW-1:0]                grant_id;
   logic                         active;
   logic                         err;

   modport master (
      input  req, req_data, tx_busy,
      output ack, done, tx_start, tx_data, grant_id, active, err
   );

   modport slave (
      output req, req_data, tx_busy,
      input  ack, done, tx_start, tx_data, grant_id, active, err
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Optional WAIT_BUSY timeout abort is built only when UART_SCHED_TIMEOUT_EN is defined.
module uart_tx_sched #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATAWIDTH = 5
`ifdef UART_SCHED_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_sched_if.master bus
);
   localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t               state;
   logic [GW-1:0]        last;
   logic [GW-1:0]        win;
   logic                 win_vld;
   logic [GW:0]          scan_sum;
   logic [GW-1:0]        scan_idx;
   logic [DATAWIDTH-1:0] data_arr [NUM_REQ];

`ifdef UART_SCHED_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CW-1:0] cnt;
`endif

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign data_arr[g] = bus.req_data[g*DATAWIDTH +: DATAWIDTH];
   end

   // first set request scanning last+1, last+2, ... modulo NUM_REQ
   always_comb begin
      win      = '0;
      win_vld  = 1'b0;
      scan_sum = '0;
      scan_idx = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         scan_sum = {1'b0, last} + (GW+1)'(k);
         if (scan_sum >= (GW+1)'(NUM_REQ))
            scan_sum = scan_sum - (GW+1)'(NUM_REQ);
         scan_idx = scan_sum[GW-1:0];
         if (!win_vld && bus.req[scan_idx]) begin
            win     = scan_idx;
            win_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last         <= GW'(NUM_REQ - 1);
         bus.ack      <= '0;
         bus.done     <= '0;
         bus.tx_start <= 1'b0;
         bus.tx_data  <= '0;
         bus.grant_id <= '0;
         bus.active   <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
         bus.err      <= 1'b0;
         cnt          <= '0;
`endif
      end else begin
         bus.ack      <= '0;
         bus.done     <= '0;
         bus.tx_start <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
         bus.err      <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               // active still high means this is the done cycle: enforce one idle cycle
               if (bus.active) begin
                  bus.active <= 1'b0;
               end else if (win_vld) begin
                  bus.tx_start  <= 1'b1;
                  bus.ack[win]  <= 1'b1;
                  bus.tx_data   <= data_arr[win];
                  bus.grant_id  <= win;
                  bus.active    <= 1'b1;
                  last          <= win;
                  state         <= WAIT_BUSY;
`ifdef UART_SCHED_TIMEOUT_EN
                  cnt           <= '0;
`endif
               end
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  state <= WAIT_DONE;
`ifdef UART_SCHED_TIMEOUT_EN
               end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                  bus.err    <= 1'b1;
                  bus.active <= 1'b0;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
`endif
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  bus.done[bus.grant_id] <= 1'b1;
                  state                  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef UART_SCHED_TIMEOUT_EN
   assign bus.err = 1'b0;
`else
`endif
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table, hand sequences and randomized frames.
// Honors UART_SCHED_TIMEOUT_EN (TIMEOUT_CYC overridden to 8).
module tb_uart_tx_sched;
   localparam int N  = 4;
   localparam int DW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_sched_if #(.NUM_REQ(N), .DATAWIDTH(DW)) bus ();

   uart_tx_sched #(
      .NUM_REQ(N),
      .DATAWIDTH(DW)
`ifdef UART_SCHED_TIMEOUT_EN
      , .TIMEOUT_CYC(8)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   int n_cmp = 0;
   int n_err = 0;
   int model_last;

   typedef struct {
      logic [3:0]  r;
      logic [19:0] d;
      int          dly;
      int          len;
      bit          keep;
      int          exp;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // reference arbiter: first requester after the last grant, circularly
   function automatic int model_win(input logic [3:0] r);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (model_last + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic do_reset(input int cyc);
      bus.req     = '0;
      bus.tx_busy = 1'b0;
      rst         = 1'b1;
      repeat (cyc) @(negedge clk);
      chk("rst_ack", bus.ack, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_tx_start", bus.tx_start, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      chk("rst_grant_id", bus.grant_id, 0);
      chk("rst_active", bus.active, 0);
      chk("rst_err", bus.err, 0);
      rst        = 1'b0;
      model_last = N - 1;
   endtask

   // One full frame starting from idle; transmitter busy for cycles [dly, dly+len) after tx_start.
   task automatic frame(input logic [3:0] r, input logic [19:0] d, input int dly, input int len,
                        input bit keep, input int exp);
      logic [4:0] ed;
      ed           = d[exp*DW +: DW];
      bus.req      = r;
      bus.req_data = d;
      @(negedge clk);
      chk("start_tx_start", bus.tx_start, 1);
      chk("start_ack", bus.ack, 32'(1) << exp);
      chk("start_tx_data", bus.tx_data, ed);
      chk("start_grant_id", bus.grant_id, exp);
      chk("start_active", bus.active, 1);
      chk("start_done", bus.done, 0);
      if (!keep) bus.req = '0;
      bus.req_data = ~d;
      bus.tx_busy  = (0 >= dly) && (0 < dly + len);
      for (int c = 1; c <= dly + len; c++) begin
         @(negedge clk);
         chk("frame_tx_start", bus.tx_start, 0);
         chk("frame_ack", bus.ack, 0);
         chk("frame_done", bus.done, 0);
         chk("frame_active", bus.active, 1);
         chk("frame_tx_data", bus.tx_data, ed);
         bus.tx_busy = (c >= dly) && (c < dly + len);
      end
      @(negedge clk);
      chk("end_done", bus.done, 32'(1) << exp);
      chk("end_active", bus.active, 1);
      chk("end_tx_start", bus.tx_start, 0);
      bus.tx_busy = 1'b0;
      @(negedge clk);
      chk("gap_active", bus.active, 0);
      chk("gap_done", bus.done, 0);
      chk("gap_tx_start", bus.tx_start, 0);
      chk("hold_grant_id", bus.grant_id, exp);
      chk("hold_tx_data", bus.tx_data, ed);
      model_last = exp;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0]  r;
      logic [19:0] d;
      int          w;

      rst          = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      bus.tx_busy  = 1'b0;

      // reset with no requests, then confirm nothing starts
      do_reset(2);
      repeat (3) begin
         @(negedge clk);
         chk("idle_tx_start", bus.tx_start, 0);
         chk("idle_active", bus.active, 0);
      end

      tbl[0]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 1, 2,  1'b1, 0};
      tbl[1]  = '{4'b1111, {5'h08, 5'h07, 5'h06, 5'h05}, 0, 1,  1'b1, 1};
      tbl[2]  = '{4'b1111, {5'h0C, 5'h0B, 5'h0A, 5'h09}, 2, 3,  1'b1, 2};
      tbl[3]  = '{4'b1111, {5'h10, 5'h0F, 5'h0E, 5'h0D}, 0, 4,  1'b1, 3};
      tbl[4]  = '{4'b1111, {5'h14, 5'h13, 5'h12, 5'h11}, 1, 1,  1'b0, 0};
      tbl[5]  = '{4'b1000, {5'h1B, 5'h00, 5'h00, 5'h1C}, 1, 2,  1'b0, 3};
      tbl[6]  = '{4'b1001, {5'h1E, 5'h00, 5'h00, 5'h1D}, 0, 2,  1'b0, 0};
      tbl[7]  = '{4'b1001, {5'h19, 5'h00, 5'h00, 5'h1A}, 2, 1,  1'b0, 3};
      tbl[8]  = '{4'b0100, {5'h0A, 5'h15, 5'h1F, 5'h01}, 3, 20, 1'b0, 2};
      tbl[9]  = '{4'b0110, {5'h11, 5'h12, 5'h13, 5'h14}, 0, 1,  1'b0, 1};
      tbl[10] = '{4'b0101, {5'h03, 5'h1F, 5'h07, 5'h0F}, 1, 1,  1'b0, 2};

      for (int i = 0; i < 11; i++)
         frame(tbl[i].r, tbl[i].d, tbl[i].dly, tbl[i].len, tbl[i].keep, tbl[i].exp);

      // randomized frames against the reference arbiter
      for (int i = 0; i < 40; i++) begin
         r = 4'($urandom_range(1, 15));
         d = 20'($urandom);
         frame(r, d, $urandom_range(0, 4), $urandom_range(1, 6), 1'($urandom_range(0, 1)),
               model_win(r));
         if ($urandom_range(0, 2) == 0) begin
            bus.req = '0;
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               chk("rnd_idle_tx_start", bus.tx_start, 0);
               chk("rnd_idle_active", bus.active, 0);
            end
         end
      end

      // reset while in WAIT_DONE: no done pulse, pointer restarts at requester 0
      bus.req = 4'b0100;
      w       = model_win(4'b0100);
      @(negedge clk);
      chk("r5_ack", bus.ack, 32'(1) << w);
      bus.req     = '0;
      bus.tx_busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("r5_active_pre", bus.active, 1);
      rst         = 1'b1;
      bus.tx_busy = 1'b0;
      @(negedge clk);
      chk("r5_active", bus.active, 0);
      chk("r5_done", bus.done, 0);
      chk("r5_tx_data", bus.tx_data, 0);
      chk("r5_grant_id", bus.grant_id, 0);
      rst        = 1'b0;
      model_last = N - 1;
      @(negedge clk);
      chk("r5_no_done", bus.done, 0);
      chk("r5_idle_active", bus.active, 0);
      frame(4'b1011, {5'h01, 5'h02, 5'h03, 5'h04}, 1, 2, 1'b0, 0);

      // transmitter never raises busy
      do_reset(1);
      bus.req      = 4'b0010;
      bus.req_data = {5'h00, 5'h00, 5'h16, 5'h00};
      @(negedge clk);
      chk("to_start", bus.tx_start, 1);
      chk("to_grant", bus.grant_id, 1);
      bus.req = '0;
`ifdef UART_SCHED_TIMEOUT_EN
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         chk("to_err", bus.err, (c == 8) ? 1 : 0);
         chk("to_active", bus.active, (c < 8) ? 1 : 0);
         chk("to_done", bus.done, 0);
      end
      model_last = 1;
      frame(4'b1111, {5'h05, 5'h06, 5'h07, 5'h08}, 0, 2, 1'b0, 2);
`else
      repeat (40) begin
         @(negedge clk);
         chk("to_err", bus.err, 0);
         chk("to_active", bus.active, 1);
         chk("to_done", bus.done, 0);
         chk("to_tx_start", bus.tx_start, 0);
      end
      do_reset(1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
